// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared op/state encodings and the data-memory request record.
package mem_stage_pkg;
  localparam int MEM_ADDR_W = 17;
  typedef enum logic [3:0] {NONE, LB, LH, LW, LBU, LHU, SB, SH, SW} mem_op_t;
  typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} mem_state_t;
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [3:0]            wstrb;
    logic [31:0]           wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_stage_lane.sv
// mem_lane: store lane steering, strobes, load extraction/extension and misalign check.
module mem_lane
  import mem_stage_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        is_store,
  output logic        misaligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_val
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = rdata[{off[1], 4'b0000} +: 16];
  assign is_store = op inside {SB, SH, SW};
  assign misaligned = (op inside {LH, LHU, SH} && off[0]) || (op inside {LW, SW} && off != 2'b00);
  assign wstrb = op == SB ? 4'b0001 << off :
                 op == SH ? (off[1] ? 4'b1100 : 4'b0011) :
                 op == SW ? 4'b1111 : 4'b0000;
  assign wdata_lane = op == SB ? {4{wdata[7:0]}} : op == SH ? {2{wdata[15:0]}} : wdata;
  assign load_val = op == LB  ? {{24{b[7]}}, b} :
                    op == LBU ? {24'b0, b} :
                    op == LH  ? {{16{h[15]}}, h} :
                    op == LHU ? {16'b0, h} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store pipeline stage with a valid/ready data port and misalign trapping.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enabled,
  input  mem_op_t           op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              completed,
  output logic [31:0]       result,
  output logic              misaligned,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);
  mem_state_t  state_q, state_d;
  mem_op_t     op_q, op_d, lane_op;
  logic [1:0]  off_q, off_d, lane_off;
  mem_req_t    req_q, req_d;
  logic [31:0] result_q, result_d;
  logic        mis_q, mis_d;
  logic        idle, l_store, l_mis;
  logic [3:0]  l_wstrb;
  logic [31:0] l_wdata, l_load;
  assign idle = state_q == IDLE;
  // The lane decodes live inputs while accepting, and the latched access afterwards.
  always_comb begin
    lane_op = op_q;
    lane_off = off_q;
    if (idle) begin
      lane_op = op;
      lane_off = addr[1:0];
    end
  end
  mem_lane u_lane (
    .op(lane_op),
    .off(lane_off),
    .wdata(wdata),
    .rdata(mem_rdata),
    .is_store(l_store),
    .misaligned(l_mis),
    .wstrb(l_wstrb),
    .wdata_lane(l_wdata),
    .load_val(l_load)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    off_d = off_q;
    req_d = req_q;
    result_d = result_q;
    mis_d = mis_q;
    case (state_q)
      IDLE: if (enabled) begin
        op_d = op;
        off_d = addr[1:0];
        mis_d = l_mis;
        if (op == NONE) begin
          result_d = addr;
          state_d = DONE;
        end else if (l_mis) begin
          result_d = '0;
          state_d = DONE;
        end else begin
          req_d = '{we: l_store, addr: MEM_ADDR_W'(addr[ADDR_W+1:2]), wstrb: l_wstrb, wdata: l_wdata};
          state_d = REQ;
        end
      end
      REQ: if (mem_ready) state_d = req_q.we ? DONE : RWAIT;
      RWAIT: if (mem_rvalid) begin
        result_d = l_load;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= NONE;
      off_q <= '0;
      req_q <= '0;
      result_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      off_q <= off_d;
      req_q <= req_d;
      result_q <= result_d;
      mis_q <= mis_d;
    end
  end
  assign busy = !idle;
  assign completed = state_q == DONE;
  assign result = result_q;
  assign misaligned = mis_q;
  assign mem_valid = state_q == REQ;
  assign mem_we = mem_valid && req_q.we;
  assign mem_wstrb = mem_valid ? req_q.wstrb : 4'b0000;
  assign mem_addr = ADDR_W'(req_q.addr);
  assign mem_wdata = req_q.wdata;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU in the core pipeline.
- Consumes the ALU result, i.e. the effective address for loads/stores or the pass-through value for every other instruction.
- Performs byte/half/word loads and stores over a valid/ready data-memory port, then hands the writeback value on with a one-cycle `completed` pulse.
- Detects misaligned accesses instead of issuing them.

Parameters:
- ADDR_W, 17, word-address width driven on mem_addr; byte address bits [ADDR_W+1:2] are used.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- enabled  in  1  start pulse, one cycle; operands valid in that cycle
- op  in  4  mem_op_t: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
- addr  in  32  ALU result (effective address, or pass-through value when op==NONE)
- wdata  in  32  store data (forwarded rs2)
- busy  out  1  high from accept until the completed cycle inclusive
- completed  out  1  one-cycle done pulse
- result  out  32  writeback value
- misaligned  out  1  valid with completed; access was not issued
- mem_valid  out  1  request valid
- mem_ready  in  1  request accepted when mem_valid && mem_ready
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word address
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset (rst high at a clk edge): state IDLE. completed, busy, misaligned, mem_valid and mem_we are 0. result, mem_addr, mem_wstrb and mem_wdata are 0.
- Reset mid-operation aborts the access: mem_valid drops the next cycle, and no completed pulse is produced for the aborted access.
- States: IDLE, REQ, RWAIT, DONE.
- IDLE:
  - enabled sampled only in IDLE; enabled while busy is ignored (upstream must not do this; the bench checks it is dropped).
  - On enabled, latch op, addr and wdata. busy goes to 1.
  - op==NONE: go to DONE; result = addr.
  - Misaligned access: go to DONE; misaligned = 1, result = 0, and no memory request. Misaligned means LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0.
  - Otherwise go to REQ with mem_valid = 1.
- REQ:
  - mem_valid held at 1, and mem_addr/mem_we/mem_wstrb/mem_wdata held stable, until mem_ready.
  - On handshake, a store goes to DONE and a load goes to RWAIT.
  - mem_valid is 0 in the cycle after the handshake.
- RWAIT: wait any number of cycles for mem_rvalid. On mem_rvalid, capture the extracted load value into result and go to DONE. The handshake cycle itself is never treated as data.
- DONE:
  - completed = 1 for exactly one cycle, then return to IDLE.
  - busy = 1 in DONE, 0 in IDLE.
  - Minimum latencies from enabled: 2 cycles for NONE/misaligned; 3 for a store with mem_ready already high; 4 for a load with mem_ready high and mem_rvalid the cycle after the handshake.
- Store lanes, with off = addr[1:0]:
  - SB: wstrb = 1<<off; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 or 1100 by addr[1]; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; wdata as given.
- Load extraction:
  - Byte = rdata[8*off +: 8] and half = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- Outside IDLE, mem_rvalid is ignored except in RWAIT.
- result holds its value after completed until the next DONE.
- misaligned is cleared on the next accepted enabled.
- mem_we/wstrb are 0 whenever mem_valid is 0.

Decomposition:
- Shared package def.sv: mem_op_t enum, the mem_state_t enum, the mem request struct (we/addr/wstrb/wdata).
- One sub-module, mem_lane: purely combinational. It handles store lane steering, strobe generation, load extraction/extension and the misalign check, so both the FSM and the bench reference model share it.

Test Plan:
- LW: addr 0x0000_0010, mem_ready=1, rvalid the next cycle with rdata 0xDEADBEEF -> mem_addr=4, wstrb=0, completed 4 cycles after enabled, result=0xDEADBEEF.
- LB/LBU: addr 0x13 with rdata 0x80FF_0000 -> LB result=0xFFFFFF80, LBU result=0x00000080. Also LH at addr 0x12 -> 0xFFFF80FF.
- SB: addr 0x21, wdata 0x1234_56AB, mem_ready held low 3 cycles -> mem_valid held with stable wstrb=0010 and wdata=0xABABABAB; completed 1 cycle after the handshake.
- Misaligned SW at addr 0x06 -> mem_valid never asserted; completed 2 cycles after enabled; misaligned=1, result=0.
- NONE: addr 0xCAFE_F00D -> result=0xCAFEF00D and completed 2 cycles after enabled. A second enabled while busy -> ignored.
- rst during RWAIT, then a late mem_rvalid -> no completed pulse, state IDLE, mem_valid=0; the next LW behaves as in the first scenario.
